mem_line_responder: RTL and testbench
=====================================

Name: mem_line_responder

Overview:
- Memory-side responder for the pipelined CPU's memory requests (instruction/data cache miss path).
- Accepts single-word reads, single-word writes and line-fill burst reads over a valid/ready request channel.
- Returns read data after a fixed multi-cycle latency on a response channel.
- Owns a word-addressed backing array; this block is the target end of the CPU's memory interface.

Parameters:
- DATA_W, 16, data word width in bits
- ADDR_W, 16, byte address width; addr[0] is ignored (16-bit words)
- MEM_WORDS, 32768, backing array depth in words; index = addr[ADDR_W-1:1] mod MEM_WORDS
- LATENCY, 4, cycles from request accept to first response word (must be >=2)
- BURST_LEN, 8, words per line fill (power of 2, >=2)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request this cycle
- req_wr  in  1  1=write, 0=read
- req_burst  in  1  1=line-fill read of BURST_LEN words (ignored when req_wr=1)
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- resp_valid  out  1  response word valid this cycle
- resp_data  out  DATA_W  read data
- resp_addr  out  ADDR_W  byte address of resp_data (bit 0 = 0)
- resp_last  out  1  final word of the current read (1 for single reads)
- busy  out  1  =~req_ready

Behaviour:
- Reset (async): state IDLE; req_ready=1, busy=0; resp_valid=0, resp_last=0, resp_data=0, resp_addr=0; all latency-pipe valid bits cleared. Array contents are NOT reset.
- Handshake: a request is accepted on the rising edge where req_valid&&req_ready. That cycle is cycle 0. req_* are sampled only then and may change freely afterwards.
- req_ready=1 only in IDLE. Requests are never queued; req_valid while req_ready=0 is ignored.
- States: IDLE, WRITE, READ_ISSUE, READ_DRAIN.
- IDLE -> WRITE on an accepted write:
  - Array updated at the end of cycle 0.
  - WRITE holds cycles 1..LATENCY-1, then returns to IDLE (req_ready=1 in cycle LATENCY).
  - No response is produced.
- IDLE -> READ_ISSUE on an accepted read:
  - Word i (i=0..N-1) is issued one per cycle into a LATENCY-deep pipe. N=1 for a single read, N=BURST_LEN for a burst.
  - Response word i has resp_valid=1 in cycle LATENCY+i, contiguous with no bubbles.
  - After the last issue: READ_DRAIN until the last word is output, then IDLE. req_ready=1 in cycle LATENCY+N.
- Burst addressing: word addresses within the aligned line base = req_addr & ~(2*BURST_LEN-1), stepping +2 with wrap inside the line. Start word depends on CRIT_WORD_FIRST_EN.
- Single-read resp_addr = req_addr with bit 0 cleared.
- Array index wraps modulo MEM_WORDS; no error signalling.
- Read data is sampled from the array at issue time. A read accepted after a write's WRITE phase always returns the new data.
- resp_last=1 only with the final resp_valid word; resp_data/resp_addr hold their last values when resp_valid=0.
- Reset asserted mid-burst: in-flight words are discarded, no further resp_valid, and the block is IDLE on deassertion.
- A write that has passed cycle 0 remains committed across reset.

Optional Feature:
- CRIT_WORD_FIRST_EN
  - Defined: burst word 0 is the requested word (req_addr[ ] word offset), then offsets increment and wrap within the line.
  - Undefined: burst always starts at the line base (offset 0) regardless of req_addr's offset. Timing is identical in both cases.

Test Plan:
- Reset then idle -> req_ready=1, resp_valid=0, busy=0; assert rst mid-cycle (async) -> outputs cleared immediately.
- Write 0x0040<=0xBEEF, then single read 0x0040 -> req_ready low cycles 1-3; read resp_valid in cycle 4 with data 0xBEEF, addr 0x0040, resp_last=1; req_ready back in cycle 5.
- Preload 0x0020..0x002E with 0x1000+i, burst read 0x0026 (macro off):
  - resp cycles 4..11, addrs 0x0020..0x002E, data 0x1000..0x1007.
  - resp_last only in cycle 11; req_ready=1 in cycle 12.
- Same burst with CRIT_WORD_FIRST_EN -> addr order 0x0026,0x0028,...,0x002E,0x0020,...,0x0024; data 0x1003..0x1007,0x1000..0x1002.
- req_valid held high with a second request during a burst -> ignored until cycle 12, accepted then; its first response in cycle 16 with no overlap.
- rst pulsed in cycle 6 of a burst -> no resp_valid after reset; next read returns correct data with standard latency.

Source files
------------

// File: rtl/mem_line_responder.sv
// Memory-side responder: single-word reads/writes and line-fill burst reads with a fixed read latency.
// Optional build macro CRIT_WORD_FIRST_EN: bursts start at the requested word instead of the line base.
module mem_line_responder #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 32768,
    parameter int LATENCY   = 4,
    parameter int BURST_LEN = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_data,
    output logic [ADDR_W-1:0] resp_addr,
    output logic              resp_last,
    output logic              busy
);
    // state      | meaning
    // IDLE       | ready to accept a request
    // WRITE      | write committed, holding off until cycle LATENCY
    // READ_ISSUE | issuing one word per cycle into the latency pipe
    // READ_DRAIN | waiting for the final word to leave the pipe
    typedef enum logic [1:0] {IDLE, WRITE, READ_ISSUE, READ_DRAIN} state_t;

    localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int OFF_W  = $clog2(BURST_LEN);
    localparam int CNT_W  = $clog2(BURST_LEN + LATENCY);
    localparam int PIPE_D = LATENCY - 1;

`ifdef CRIT_WORD_FIRST_EN
    localparam bit CRIT_FIRST = 1'b1;
`else
    localparam bit CRIT_FIRST = 1'b0;
`endif

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic              accept, issue, issue_last;
    logic [ADDR_W-1:0] cur_addr, start_addr;
    logic [DATA_W-1:0] mem [MEM_WORDS];
    logic [PIPE_D-1:0] pv, pl;
    logic [DATA_W-1:0] pd [PIPE_D];
    logic [ADDR_W-1:0] pa [PIPE_D];

    function automatic logic [IDX_W-1:0] mem_idx(input logic [ADDR_W-1:0] a);
        logic [31:0] w;
        w = 32'(a[ADDR_W-1:1]);
        return IDX_W'(w % 32'(MEM_WORDS));
    endfunction

    assign req_ready = (state == IDLE);
    assign busy      = ~req_ready;
    assign accept    = req_valid && req_ready;

    always_comb begin
        start_addr    = req_addr;
        start_addr[0] = 1'b0;
        if (req_burst && !CRIT_FIRST)
            start_addr[OFF_W:1] = '0;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        issue      = 1'b0;
        issue_last = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_wr) begin
                        state_next = WRITE;
                        cnt_next   = CNT_W'(LATENCY - 2);
                    end else begin
                        state_next = READ_ISSUE;
                        cnt_next   = req_burst ? CNT_W'(BURST_LEN - 1) : '0;
                    end
                end
            end
            WRITE: begin
                if (cnt == '0) state_next = IDLE;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            READ_ISSUE: begin
                issue      = 1'b1;
                issue_last = (cnt == '0);
                if (cnt == '0) state_next = READ_DRAIN;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            READ_DRAIN: begin
                if (resp_valid && resp_last) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Array has no reset so committed writes survive a reset pulse.
    always_ff @(posedge clk) begin
        if (accept && req_wr && !rst)
            mem[mem_idx(req_addr)] <= req_wdata;
    end

    // Data/address stages only advance behind a valid word so the outputs hold between responses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_addr <= '0;
            pv       <= '0;
            pl       <= '0;
            for (int k = 0; k < PIPE_D; k++) begin
                pd[k] <= '0;
                pa[k] <= '0;
            end
        end else begin
            if (accept && !req_wr)
                cur_addr <= start_addr;
            else if (issue)
                cur_addr[OFF_W:1] <= cur_addr[OFF_W:1] + OFF_W'(1);
            pv[0] <= issue;
            pl[0] <= issue_last;
            if (issue) begin
                pd[0] <= mem[mem_idx(cur_addr)];
                pa[0] <= cur_addr;
            end
            for (int k = 1; k < PIPE_D; k++) begin
                pv[k] <= pv[k-1];
                pl[k] <= pl[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                    pa[k] <= pa[k-1];
                end
            end
        end
    end

    assign resp_valid = pv[PIPE_D-1];
    assign resp_last  = pl[PIPE_D-1];
    assign resp_data  = pd[PIPE_D-1];
    assign resp_addr  = pa[PIPE_D-1];

endmodule

// File: tb/tb_mem_line_responder.sv
// Self-checking bench for mem_line_responder: vector table, random traffic against a reference model,
// and hand-written reset / held-request sequences.
module tb_mem_line_responder;
    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 16;
    localparam int MEM_WORDS = 32768;
    localparam int LAT       = 4;
    localparam int BL        = 8;

`ifdef CRIT_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_wr = 1'b0;
    logic              req_burst = 1'b0;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              req_ready, resp_valid, resp_last, busy;
    logic [DATA_W-1:0] resp_data;
    logic [ADDR_W-1:0] resp_addr;

    mem_line_responder #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS),
        .LATENCY(LAT), .BURST_LEN(BL)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_burst(req_burst), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_addr(resp_addr),
        .resp_last(resp_last), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        bit          burst;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] e_data;
        logic [15:0] e_addr;
        int          e_ready;
    } vec_t;

    vec_t        tbl [15];
    logic [15:0] ref_mem [MEM_WORDS];
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Word address of response word i, from the line/wrap rules.
    function automatic logic [15:0] exp_addr(input logic [15:0] a, input bit burst, input int i);
        int base, start;
        if (!burst) return a & 16'hFFFE;
        base  = int'(a) - (int'(a) % (2 * BL));
        start = CWF ? ((int'(a) / 2) % BL) : 0;
        return 16'(base + 2 * ((start + i) % BL));
    endfunction

    function automatic logic [15:0] model_data(input logic [15:0] a);
        return ref_mem[(int'(a) / 2) % MEM_WORDS];
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!req_ready && n < 64) begin
            next_cycle();
            n++;
        end
        chk("wait_ready", req_ready, 1);
    endtask

    // Issues one request and checks every cycle up to the return of req_ready.
    task automatic do_req(input bit wr, input bit burst, input logic [15:0] addr,
                          input logic [15:0] wdata, output logic [15:0] fd,
                          output logic [15:0] fa, output int rc);
        int n, last_cyc;
        bit seen;
        fd = '0; fa = '0; rc = -1; seen = 0;
        wait_ready();
        req_valid = 1; req_wr = wr; req_burst = burst; req_addr = addr; req_wdata = wdata;
        next_cycle();
        req_valid = 0;
        req_wr    = 1'($urandom_range(0, 1));
        req_burst = 1'($urandom_range(0, 1));
        req_addr  = 16'($urandom);
        req_wdata = 16'($urandom);
        if (wr) ref_mem[(int'(addr) / 2) % MEM_WORDS] = wdata;
        n = wr ? 0 : (burst ? BL : 1);
        last_cyc = wr ? LAT : LAT + n;
        for (int cyc = 1; cyc <= last_cyc; cyc++) begin
            bit ev, er;
            int w;
            er = (cyc == last_cyc);
            ev = !wr && cyc >= LAT && cyc < LAT + n;
            w  = cyc - LAT;
            if (req_ready && rc < 0) rc = cyc;
            chk($sformatf("ready c%0d", cyc), req_ready, er);
            chk($sformatf("busy c%0d", cyc), busy, !er);
            chk($sformatf("resp_valid c%0d", cyc), resp_valid, ev);
            if (ev) begin
                chk($sformatf("resp_addr w%0d", w), resp_addr, exp_addr(addr, burst, w));
                chk($sformatf("resp_data w%0d", w), resp_data, model_data(exp_addr(addr, burst, w)));
                chk($sformatf("resp_last w%0d", w), resp_last, w == n - 1);
                if (!seen) begin
                    fd = resp_data; fa = resp_addr; seen = 1;
                end
            end
            if (cyc < last_cyc) next_cycle();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] fd, fa, a;
        int          rc, op;
        bit          b;

        tbl[0]  = '{1'b1, 1'b0, 16'h0040, 16'hBEEF, 16'h0000, 16'h0000, 4};
        tbl[1]  = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hBEEF, 16'h0040, 5};
        for (int i = 0; i < 8; i++)
            tbl[2+i] = '{1'b1, 1'b0, 16'(16'h0020 + 2 * i), 16'(16'h1000 + i), 16'h0000, 16'h0000, 4};
        tbl[10] = '{1'b0, 1'b1, 16'h0026, 16'h0000,
                    CWF ? 16'h1003 : 16'h1000, CWF ? 16'h0026 : 16'h0020, 12};
        tbl[11] = '{1'b0, 1'b0, 16'h0041, 16'h0000, 16'hBEEF, 16'h0040, 5};
        tbl[12] = '{1'b0, 1'b1, 16'h002F, 16'h0000,
                    CWF ? 16'h1007 : 16'h1000, CWF ? 16'h002E : 16'h0020, 12};
        tbl[13] = '{1'b1, 1'b1, 16'h0042, 16'h5A5A, 16'h0000, 16'h0000, 4};
        tbl[14] = '{1'b0, 1'b0, 16'h0042, 16'h0000, 16'h5A5A, 16'h0042, 5};

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk("rst_ready", req_ready, 1);
        chk("rst_valid", resp_valid, 0);
        rst = 0;
        next_cycle();
        chk("idle_ready", req_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_valid", resp_valid, 0);
        chk("idle_last", resp_last, 0);
        chk("idle_data", resp_data, 0);
        chk("idle_addr", resp_addr, 0);

        // Vector table
        for (int i = 0; i < 15; i++) begin
            do_req(tbl[i].wr, tbl[i].burst, tbl[i].addr, tbl[i].wdata, fd, fa, rc);
            chk($sformatf("vec%0d ready_cycle", i), rc, tbl[i].e_ready);
            if (!tbl[i].wr) begin
                chk($sformatf("vec%0d first_data", i), fd, tbl[i].e_data);
                chk($sformatf("vec%0d first_addr", i), fa, tbl[i].e_addr);
            end
        end

        // Random traffic over a preloaded region
        for (int i = 0; i < 128; i++)
            do_req(1'b1, 1'b0, 16'(16'h0100 + 2 * i), 16'($urandom), fd, fa, rc);
        for (int i = 0; i < 40; i++) begin
            op = int'($urandom_range(0, 2));
            a  = 16'(16'h0100 + $urandom_range(0, 255));
            b  = (op == 2) || (op == 0 && $urandom_range(0, 1) == 1);
            do_req(op == 0, b, a, 16'($urandom), fd, fa, rc);
        end

        // Second request held during a burst: ignored until cycle 12
        wait_ready();
        req_valid = 1; req_wr = 0; req_burst = 1; req_addr = 16'h0020;
        next_cycle();
        req_burst = 0; req_addr = 16'h0040;
        for (int cyc = 1; cyc <= 17; cyc++) begin
            bit ev, er;
            if (cyc == 13) req_valid = 0;
            ev = (cyc >= 4 && cyc <= 11) || cyc == 16;
            er = (cyc == 12) || (cyc == 17);
            chk($sformatf("held ready c%0d", cyc), req_ready, er);
            chk($sformatf("held valid c%0d", cyc), resp_valid, ev);
            if (ev && cyc <= 11) begin
                chk("held burst addr", resp_addr, exp_addr(16'h0020, 1'b1, cyc - 4));
                chk("held burst data", resp_data, model_data(exp_addr(16'h0020, 1'b1, cyc - 4)));
            end
            if (cyc == 16) begin
                chk("held second addr", resp_addr, 16'h0040);
                chk("held second data", resp_data, model_data(16'h0040));
                chk("held second last", resp_last, 1);
            end
            if (cyc < 17) next_cycle();
        end

        // Reset pulsed in cycle 6 of a burst
        wait_ready();
        req_valid = 1; req_wr = 0; req_burst = 1; req_addr = 16'h0026;
        next_cycle();
        req_valid = 0;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            chk($sformatf("rstburst valid c%0d", cyc), resp_valid, cyc >= 4);
            if (cyc < 6) next_cycle();
        end
        #2 rst = 1;
        #1;
        chk("async_rst valid", resp_valid, 0);
        chk("async_rst data", resp_data, 0);
        chk("async_rst addr", resp_addr, 0);
        chk("async_rst last", resp_last, 0);
        chk("async_rst ready", req_ready, 1);
        chk("async_rst busy", busy, 0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        for (int i = 0; i < 12; i++) begin
            next_cycle();
            chk("post_rst valid", resp_valid, 0);
            chk("post_rst ready", req_ready, 1);
        end
        do_req(1'b0, 1'b1, 16'h0026, 16'h0000, fd, fa, rc);
        chk("post_rst burst ready_cycle", rc, 12);
        chk("post_rst burst first_data", fd, CWF ? 16'h1003 : 16'h1000);

        // Write stays committed across a reset right after acceptance
        wait_ready();
        req_valid = 1; req_wr = 1; req_burst = 0; req_addr = 16'h0048; req_wdata = 16'h7777;
        next_cycle();
        req_valid = 0; req_wr = 0;
        ref_mem[16'h0048 / 2] = 16'h7777;
        #2 rst = 1;
        @(negedge clk);
        rst = 0;
        do_req(1'b0, 1'b0, 16'h0048, 16'h0000, fd, fa, rc);
        chk("wr_across_rst data", fd, 16'h7777);
        chk("wr_across_rst ready_cycle", rc, 5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
